// File: rtl/rsa_decrypt_pkg.sv
// Shared definitions for the RSA decryption core: FSM encoding, multiplier latency
// and the finish-latency formula used by both the RTL and its bench.
package rsa_decrypt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SQR,
    MUL,
    DONE
  } state_t;

  // Cycles per modular multiply: issue + one per operand bit + done.
  function automatic int mm_lat(input int width);
    return 2 * width + 2;
  endfunction

  function automatic int op_count(input int width, input bit const_time, input logic [63:0] d);
    int ops;
    ops = 2 * width;
    if (const_time) begin
      ops = 4 * width;
    end else begin
      for (int i = 0; i < 2 * width; i++) begin
        if (d[i]) ops++;
      end
    end
    return ops;
  endfunction

  function automatic int finish_cycle(input int width, input bit const_time, input logic [63:0] d);
    return 2 + op_count(width, const_time, d) * mm_lat(width);
  endfunction

endpackage

// File: rtl/rsa_decrypt_if.sv
// Request/response bundle of the RSA decryption core.
interface rsa_decrypt_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [2*WIDTH-1:0] c;
  logic [2*WIDTH-1:0] d;
  logic [2*WIDTH-1:0] n;
  logic [2*WIDTH-1:0] m;
  logic               busy;
  logic               finish;
  logic               err;

  modport master (output start, c, d, n, input m, busy, finish, err);
  modport slave  (input start, c, d, n, output m, busy, finish, err);
endinterface

// File: rtl/rsa_decrypt_mod_mult.sv
// Interleaved shift-add modular multiplier: result = a*b mod n, one bit of b per cycle,
// MSB first. Operands must already be reduced (a, b < n).
module rsa_decrypt_mod_mult
  import rsa_decrypt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [2*WIDTH-1:0] n,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int W2   = 2 * WIDTH;
  localparam int ITER = mm_lat(WIDTH) - 2;
  localparam int CW   = $clog2(ITER + 1);

  logic [W2-1:0] a_reg, b_reg, n_reg, r, r_next;
  logic [CW-1:0] cnt;
  logic [W2:0]   n_ext, dbl, dbl_sub, dbl_mod, sum, sum_sub;

  // One iteration: r = 2r mod n, then r = r + a mod n when the current b bit is set.
  // Both steps stay below 2n, so a single conditional subtract suffices.
  always_comb begin
    n_ext   = {1'b0, n_reg};
    dbl     = {r, 1'b0};
    dbl_sub = dbl - n_ext;
    dbl_mod = (dbl >= n_ext) ? dbl_sub : dbl;
    sum     = dbl_mod + {1'b0, a_reg};
    sum_sub = sum - n_ext;
    r_next  = dbl_mod[W2-1:0];
    if (b_reg[W2-1]) begin
      r_next = (sum >= n_ext) ? sum_sub[W2-1:0] : sum[W2-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      n_reg <= '0;
      r     <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_reg <= a;
        b_reg <= b;
        n_reg <= n;
        r     <= '0;
        cnt   <= CW'(ITER);
      end else if (cnt != '0) begin
        r     <= r_next;
        b_reg <= {b_reg[W2-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign result = r;

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption core: m = c^d mod n by left-to-right square-and-multiply over all
// exponent bits; CONST_TIME makes the multiply unconditional so latency ignores d.
module rsa_decrypt
  import rsa_decrypt_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit CONST_TIME = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  rsa_decrypt_if.slave bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int IW = $clog2(W2);

  state_t        state, state_next;
  logic [W2-1:0] c_reg, d_reg, n_reg, acc, acc_next, m_reg;
  logic [IW-1:0] idx;
  logic          err_reg, issue;
  logic          mm_start, mm_done;
  logic [W2-1:0] mm_b, mm_result;
  logic          d_bit, last, bad, advance;

  assign d_bit   = d_reg[idx];
  assign last    = (idx == '0);
  assign bad     = (n_reg < W2'(2)) || (c_reg >= n_reg);
  assign advance = mm_done && ((state == SQR && !(d_bit || CONST_TIME)) || state == MUL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.start) state_next = CHECK;
      CHECK: state_next = bad ? DONE : SQR;
      SQR: begin
        if (mm_done) begin
          if (d_bit || CONST_TIME) state_next = MUL;
          else if (last)           state_next = DONE;
          else                     state_next = SQR;
        end
      end
      MUL:     if (mm_done) state_next = last ? DONE : SQR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.finish = (state == DONE);
    mm_start   = issue;
    mm_b       = (state == MUL) ? c_reg : acc;
  end

  // A discarded multiply (CONST_TIME with a zero exponent bit) leaves acc untouched.
  always_comb begin
    acc_next = acc;
    if (mm_done && (state == SQR || (state == MUL && d_bit))) acc_next = mm_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg   <= '0;
      d_reg   <= '0;
      n_reg   <= '0;
      acc     <= '0;
      idx     <= '0;
      m_reg   <= '0;
      err_reg <= 1'b0;
      issue   <= 1'b0;
    end else begin
      issue <= (state_next == SQR || state_next == MUL) && (state_next != state || mm_done);
      acc   <= acc_next;
      if (state == IDLE && bus.start) begin
        c_reg <= bus.c;
        d_reg <= bus.d;
        n_reg <= bus.n;
        acc   <= W2'(1);
        idx   <= IW'(W2 - 1);
      end
      if (advance && !last) idx <= idx - 1'b1;
      if (state_next == DONE) begin
        m_reg   <= (state == CHECK) ? '0 : acc_next;
        err_reg <= (state == CHECK);
      end
    end
  end

  assign bus.m   = m_reg;
  assign bus.err = err_reg;

  rsa_decrypt_mod_mult #(.WIDTH(WIDTH)) u_mod_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mm_start),
    .a      (acc),
    .b      (mm_b),
    .n      (n_reg),
    .done   (mm_done),
    .result (mm_result)
  );

endmodule

// File: tb/tb_rsa_decrypt.sv
// Bench for rsa_decrypt: a CONST_TIME=0 and a CONST_TIME=1 instance side by side,
// directed table, hand-written corner sequences and randomized modexp against a model.
module tb_rsa_decrypt;

  localparam int WIDTH = 8;
  localparam int LIMIT = 700;

  typedef struct {
    logic [15:0] c;
    logic [15:0] d;
    logic [15:0] n;
    logic [15:0] m;
    logic        err;
    int          lat0;
    int          lat1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [2];
  logic [15:0] c_v     [2];
  logic [15:0] d_v     [2];
  logic [15:0] n_v     [2];
  logic        fin_w   [2];
  logic        busy_w  [2];
  logic        err_w   [2];
  logic [15:0] m_w     [2];

  int n_vec  = 0;
  int n_miss = 0;

  vec_t        tbl [7];
  logic [15:0] m0, m1;
  logic        e0, e1;
  int          l0, l1, fin_cnt;

  rsa_decrypt_if #(.WIDTH(WIDTH)) bus0 ();
  rsa_decrypt_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus0.start = start_v[0];
  assign bus0.c     = c_v[0];
  assign bus0.d     = d_v[0];
  assign bus0.n     = n_v[0];
  assign bus1.start = start_v[1];
  assign bus1.c     = c_v[1];
  assign bus1.d     = d_v[1];
  assign bus1.n     = n_v[1];
  assign fin_w[0]   = bus0.finish;
  assign fin_w[1]   = bus1.finish;
  assign busy_w[0]  = bus0.busy;
  assign busy_w[1]  = bus1.busy;
  assign err_w[0]   = bus0.err;
  assign err_w[1]   = bus1.err;
  assign m_w[0]     = bus0.m;
  assign m_w[1]     = bus1.m;

  rsa_decrypt #(.WIDTH(WIDTH), .CONST_TIME(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rsa_decrypt #(.WIDTH(WIDTH), .CONST_TIME(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Starts one operation on instance 'which' (start sampled at the end of cycle 0) and
  // waits for finish; lat is the cycle index of finish, -1 if it never came.
  task automatic applyStimulus(input int which, input logic [15:0] c, input logic [15:0] d,
                               input logic [15:0] n, input int glitch_at,
                               output logic [15:0] m, output logic e, output int lat);
    lat = -1;
    m   = '0;
    e   = 1'b0;
    @(negedge clk);
    c_v[which]     = c;
    d_v[which]     = d;
    n_v[which]     = n;
    start_v[which] = 1'b1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      start_v[which] = (k == glitch_at);
      if (k == glitch_at) begin
        c_v[which] = 16'd5;
        d_v[which] = 16'd7;
      end
      if (fin_w[which]) begin
        m   = m_w[which];
        e   = err_w[which];
        lat = k;
        break;
      end
    end
  endtask

  // Right-to-left binary exponentiation with plain modular arithmetic.
  function automatic void refModel(input logic [15:0] c, input logic [15:0] d, input logic [15:0] n,
                                   input bit ct, output logic [15:0] m, output logic e, output int lat);
    longint res, base, nn;
    if (n < 16'd2 || c >= n) begin
      m   = '0;
      e   = 1'b1;
      lat = 2;
      return;
    end
    nn   = longint'(n);
    res  = 1;
    base = longint'(c);
    for (int i = 0; i < 16; i++) begin
      if (d[i]) res = (res * base) % nn;
      base = (base * base) % nn;
    end
    m   = 16'(res);
    e   = 1'b0;
    lat = 2 + (ct ? 4 * WIDTH : 2 * WIDTH + $countones(d)) * (2 * WIDTH + 2);
  endfunction

  task automatic randomRun(input int which, input int count);
    logic [15:0] c, d, n, m_got, m_exp;
    logic        e_got, e_exp;
    int          l_got, l_exp;
    for (int i = 0; i < count; i++) begin
      n = 16'($urandom_range(65535, 2));
      c = 16'($urandom % n);
      d = (i == 0) ? 16'hffff : 16'($urandom);
      applyStimulus(which, c, d, n, 0, m_got, e_got, l_got);
      refModel(c, d, n, which == 1, m_exp, e_exp, l_exp);
      checkOutput($sformatf("rand%0d_%0d_m", which, i), m_got, m_exp);
      checkOutput($sformatf("rand%0d_%0d_err", which, i), e_got, e_exp);
      checkOutput($sformatf("rand%0d_%0d_lat", which, i), l_got, l_exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      c_v[i]     = '0;
      d_v[i]     = '0;
      n_v[i]     = '0;
    end
    tbl[0] = '{16'd2790, 16'd2753, 16'd3233, 16'd65,   1'b0, 380, 578};
    tbl[1] = '{16'd2790, 16'd1,    16'd3233, 16'd2790, 1'b0, 308, 578};
    tbl[2] = '{16'd1234, 16'd0,    16'd3233, 16'd1,    1'b0, 290, 578};
    tbl[3] = '{16'd0,    16'd17,   16'd3233, 16'd0,    1'b0, 326, 578};
    tbl[4] = '{16'd5,    16'd3,    16'd1,    16'd0,    1'b1, 2,   2};
    tbl[5] = '{16'd3233, 16'd5,    16'd3233, 16'd0,    1'b1, 2,   2};
    tbl[6] = '{16'd7,    16'd9,    16'd0,    16'd0,    1'b1, 2,   2};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset%0d_m", i), m_w[i], 16'd0);
      checkOutput($sformatf("reset%0d_busy", i), busy_w[i], 1'b0);
      checkOutput($sformatf("reset%0d_finish", i), fin_w[i], 1'b0);
      checkOutput($sformatf("reset%0d_err", i), err_w[i], 1'b0);
    end
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fork
        applyStimulus(0, tbl[i].c, tbl[i].d, tbl[i].n, 0, m0, e0, l0);
        applyStimulus(1, tbl[i].c, tbl[i].d, tbl[i].n, 0, m1, e1, l1);
      join
      checkOutput($sformatf("tbl%0d_m0", i), m0, tbl[i].m);
      checkOutput($sformatf("tbl%0d_err0", i), e0, tbl[i].err);
      checkOutput($sformatf("tbl%0d_lat0", i), l0, tbl[i].lat0);
      checkOutput($sformatf("tbl%0d_m1", i), m1, tbl[i].m);
      checkOutput($sformatf("tbl%0d_err1", i), e1, tbl[i].err);
      checkOutput($sformatf("tbl%0d_lat1", i), l1, tbl[i].lat1);
    end

    // A start pulse with different operands in the middle of a run must be ignored.
    applyStimulus(0, 16'd2790, 16'd2753, 16'd3233, 50, m0, e0, l0);
    checkOutput("glitch_m", m0, 16'd65);
    checkOutput("glitch_lat", l0, 380);

    // Reset in cycle 100 of a run aborts it with no finish pulse.
    fin_cnt = 0;
    @(negedge clk);
    c_v[0]     = 16'd2790;
    d_v[0]     = 16'd2753;
    n_v[0]     = 16'd3233;
    start_v[0] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (fin_w[0]) fin_cnt++;
    end
    checkOutput("pre_rst_busy", busy_w[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", busy_w[0], 1'b0);
    checkOutput("rst_finish", fin_w[0], 1'b0);
    checkOutput("rst_m", m_w[0], 16'd0);
    rst = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (fin_w[0]) fin_cnt++;
    end
    checkOutput("rst_no_finish", fin_cnt, 0);

    // start coinciding with finish must not launch a new operation.
    @(negedge clk);
    c_v[0]     = 16'd5;
    d_v[0]     = 16'd3;
    n_v[0]     = 16'd1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    checkOutput("coinc_finish", fin_w[0], 1'b1);
    checkOutput("coinc_err", err_w[0], 1'b1);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    checkOutput("coinc_busy", busy_w[0], 1'b0);

    fork
      randomRun(0, 100);
      randomRun(1, 100);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
